// File: rtl/mine_placer.sv
// mine_placer: places BOMB_COUNT bombs on a GRID_SIZE x GRID_SIZE board.
// A free-running 8-bit LFSR supplies one candidate cell per cycle. The cell
// at safe_idx, which is captured when start is taken, never receives a bomb.
//
// Ports:
//   clock     - single clock; all state changes on its rising edge
//   reset     - asynchronous active-low reset
//   start     - request a new placement; taken only in IDLE
//   abort     - cancel a placement in progress (CLEAR or SAMPLE)
//   safe_idx  - cell index (row*GRID_SIZE+col) that must stay bomb-free
//   bombGrid  - placed bomb bitmap; bit i is cell i
//   busy      - high while clearing or sampling
//   done      - one-cycle completion pulse
//   placed    - number of bombs placed so far
module mine_placer #(
    parameter int unsigned GRID_SIZE  = 3,
    parameter int unsigned BOMB_COUNT = 2,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [7:0]                       safe_idx,
    output logic [GRID_SIZE*GRID_SIZE-1:0]   bombGrid,
    output logic                             busy,
    output logic                             done,
    output logic [7:0]                       placed
);

    localparam int unsigned    CELLS   = GRID_SIZE * GRID_SIZE;
    localparam logic [7:0]     TARGET  = 8'(BOMB_COUNT);
    localparam logic [CELLS-1:0] ONE   = CELLS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q,  state_d;
    logic [7:0]       lfsr_q,   lfsr_d;
    logic [7:0]       safe_q,   safe_d;
    logic [CELLS-1:0] grid_q,   grid_d;
    logic [7:0]       placed_q, placed_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [7:0]       cand;
    logic [CELLS-1:0] cand_bit;
    logic             cand_ok;

    // Candidate cell from the LFSR; out-of-range candidates shift out to an
    // all-zero mask, which doubles as the range check.
    always_comb begin
        cand     = lfsr_q - 8'd1;
        cand_bit = ONE << cand;
        cand_ok  = (cand_bit != '0) && (cand != safe_q) && ((grid_q & cand_bit) == '0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        safe_d   = safe_q;
        grid_d   = grid_q;
        placed_d = placed_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    safe_d  = safe_idx;
                end
            end
            S_CLEAR: begin
                grid_d   = '0;
                placed_d = 8'd0;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (BOMB_COUNT == 0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Abort wins over a completing placement in the same cycle.
                if (abort) begin
                    state_d  = S_IDLE;
                    grid_d   = '0;
                    placed_d = 8'd0;
                end else if (cand_ok) begin
                    grid_d   = grid_q | cand_bit;
                    placed_d = placed_q + 8'd1;
                    if (placed_q + 8'd1 == TARGET) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CLEAR) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= SEED;
            safe_q   <= 8'd0;
            grid_q   <= '0;
            placed_q <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            safe_q   <= safe_d;
            grid_q   <= grid_d;
            placed_q <= placed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bombGrid = grid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign placed   = placed_q;

endmodule

// File: tb/tb_mine_placer.sv
// Testbench for mine_placer: three instances on a 3x3 board with 2, 0 and 8
// bombs, checked against a reference that replays the placement rules on a
// bench-side copy of the LFSR sequence.
module tb_mine_placer;

    localparam logic [7:0] SEED  = 8'hA5;
    localparam int         LIMIT = 600;
    localparam int         LIMIT_FULL = 3000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [7:0] safe_a  = 8'd0;
    logic [8:0] grid_a;
    logic       busy_a, done_a;
    logic [7:0] placed_a;

    logic       start_z = 1'b0, abort_z = 1'b0;
    logic [7:0] safe_z  = 8'd0;
    logic [8:0] grid_z;
    logic       busy_z, done_z;
    logic [7:0] placed_z;

    logic       start_f = 1'b0, abort_f = 1'b0;
    logic [7:0] safe_f  = 8'd0;
    logic [8:0] grid_f;
    logic       busy_f, done_f;
    logic [7:0] placed_f;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_lfsr;
    logic [8:0] last_a = 9'd0;

    always #5 clock = ~clock;

    mine_placer #(.GRID_SIZE(3), .BOMB_COUNT(2), .SEED(SEED)) u_def (
        .clock(clock), .reset(reset), .start(start_a), .abort(abort_a), .safe_idx(safe_a),
        .bombGrid(grid_a), .busy(busy_a), .done(done_a), .placed(placed_a));

    mine_placer #(.GRID_SIZE(3), .BOMB_COUNT(0), .SEED(SEED)) u_zero (
        .clock(clock), .reset(reset), .start(start_z), .abort(abort_z), .safe_idx(safe_z),
        .bombGrid(grid_z), .busy(busy_z), .done(done_z), .placed(placed_z));

    mine_placer #(.GRID_SIZE(3), .BOMB_COUNT(8), .SEED(SEED)) u_full (
        .clock(clock), .reset(reset), .start(start_f), .abort(abort_f), .safe_idx(safe_f),
        .bombGrid(grid_f), .busy(busy_f), .done(done_f), .placed(placed_f));

    // One LFSR step for x^8+x^6+x^5+x^4+1, written as a parity over a tap mask.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [7:0] taps;
        taps = 8'b1011_1000;
        return {v[6:0], ^(v & taps)};
    endfunction

    // Bench copy of the free-running LFSR; matches the DUT value at each negedge.
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    // Given the LFSR value when start is driven, return the final board and the
    // number of sampling cycles; done is expected 2+n cycles after start.
    function automatic void predict(input logic [7:0] l0, input int safe, input int bc,
                                    output logic [8:0] grid, output int n);
        bit         taken [0:8];
        logic [7:0] s;
        int         cnt;
        int         c;
        for (int i = 0; i < 9; i++) taken[i] = 1'b0;
        s   = lfsr_next(lfsr_next(l0));
        cnt = 0;
        n   = 0;
        while (cnt < bc && n <= 255 * bc) begin
            c = int'(s) - 1;
            if (c < 9 && c != safe) begin
                if (!taken[c]) begin
                    taken[c] = 1'b1;
                    cnt++;
                end
            end
            s = lfsr_next(s);
            n++;
        end
        grid = 9'd0;
        for (int i = 0; i < 9; i++) grid[i] = taken[i];
    endfunction

    function automatic int popc(input logic [8:0] v);
        int k = 0;
        for (int i = 0; i < 9; i++) k += int'(v[i]);
        return k;
    endfunction

    function automatic logic [8:0] safe_mask(input int safe);
        return (safe < 9) ? (9'd1 << safe) : 9'd0;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        total++;
        if ({grid_a, busy_a, done_a, placed_a} !== 19'd0) begin
            bad++; $display("FAIL reset_def got=%0h want=0", {grid_a, busy_a, done_a, placed_a});
        end
        total++;
        if ({grid_z, busy_z, done_z, placed_z} !== 19'd0) begin
            bad++; $display("FAIL reset_zero got=%0h want=0", {grid_z, busy_z, done_z, placed_z});
        end
        total++;
        if ({grid_f, busy_f, done_f, placed_f} !== 19'd0) begin
            bad++; $display("FAIL reset_full got=%0h want=0", {grid_f, busy_f, done_f, placed_f});
        end
        repeat (3) @(negedge clock);
        total++;
        if ({grid_a, busy_a, done_a, placed_a} !== 19'd0) begin
            bad++; $display("FAIL reset_hold got=%0h want=0", {grid_a, busy_a, done_a, placed_a});
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int         safes [6] = '{4, 9, 200, 255, 0, 8};
        int         safe, n, cyc, gap;
        logic [8:0] exp;
        for (int i = 0; i < 10; i++) begin
            safe = (i < 6) ? safes[i] : int'($urandom_range(0, 8));
            gap  = (i == 0) ? 0 : int'($urandom_range(0, 20));
            repeat (gap) @(negedge clock);
            predict(m_lfsr, safe, 2, exp, n);
            start_a = 1'b1;
            safe_a  = 8'(safe);
            @(negedge clock);
            start_a = 1'b0;
            safe_a  = 8'($urandom);
            total++;
            if (busy_a !== 1'b1) begin
                bad++; $display("FAIL basic_busy run=%0d got=%b want=1", i, busy_a);
            end
            cyc = 1;
            while (done_a !== 1'b1 && cyc < LIMIT) begin
                @(negedge clock);
                cyc++;
            end
            total++;
            if (cyc != 2 + n) begin
                bad++; $display("FAIL basic_latency run=%0d got=%0d want=%0d", i, cyc, 2 + n);
            end
            total++;
            if (grid_a !== exp) begin
                bad++; $display("FAIL basic_grid run=%0d got=%b want=%b", i, grid_a, exp);
            end
            total++;
            if (placed_a !== 8'd2) begin
                bad++; $display("FAIL basic_placed run=%0d got=%0d want=2", i, placed_a);
            end
            total++;
            if (popc(grid_a) != 2 || (grid_a & safe_mask(safe)) != 9'd0) begin
                bad++; $display("FAIL basic_rules run=%0d got=%b want popcount 2, safe %0d clear",
                                i, grid_a, safe);
            end
            @(negedge clock);
            total++;
            if (done_a !== 1'b0 || busy_a !== 1'b0 || grid_a !== exp) begin
                bad++; $display("FAIL basic_after run=%0d got done=%b busy=%b grid=%b want 0 0 %b",
                                i, done_a, busy_a, grid_a, exp);
            end
            last_a = exp;
        end
    endtask

    task automatic test_zero();
        for (int i = 0; i < 2; i++) begin
            start_z = 1'b1;
            safe_z  = 8'($urandom_range(0, 8));
            @(negedge clock);
            start_z = 1'b0;
            total++;
            if (busy_z !== 1'b1 || done_z !== 1'b0) begin
                bad++; $display("FAIL zero_c1 got busy=%b done=%b want 1 0", busy_z, done_z);
            end
            @(negedge clock);
            total++;
            if (done_z !== 1'b1 || busy_z !== 1'b0 || grid_z !== 9'd0 || placed_z !== 8'd0) begin
                bad++; $display("FAIL zero_c2 got done=%b busy=%b grid=%b placed=%0d want 1 0 0 0",
                                done_z, busy_z, grid_z, placed_z);
            end
            @(negedge clock);
            total++;
            if (done_z !== 1'b0) begin
                bad++; $display("FAIL zero_pulse got=%b want=0", done_z);
            end
        end
    endtask

    task automatic test_full();
        int         safe, n, cyc;
        logic [8:0] exp;
        for (int i = 0; i < 2; i++) begin
            safe = (i == 0) ? 0 : int'($urandom_range(1, 8));
            predict(m_lfsr, safe, 8, exp, n);
            start_f = 1'b1;
            safe_f  = 8'(safe);
            @(negedge clock);
            start_f = 1'b0;
            cyc = 1;
            while (done_f !== 1'b1 && cyc < LIMIT_FULL) begin
                @(negedge clock);
                cyc++;
            end
            total++;
            if (cyc != 2 + n) begin
                bad++; $display("FAIL full_latency got=%0d want=%0d", cyc, 2 + n);
            end
            total++;
            if (grid_f !== (~safe_mask(safe))) begin
                bad++; $display("FAIL full_grid got=%b want=%b", grid_f, ~safe_mask(safe));
            end
            total++;
            if (placed_f !== 8'd8) begin
                bad++; $display("FAIL full_placed got=%0d want=8", placed_f);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_abort();
        int         safe, n, cyc, k, dones;
        logic [8:0] exp;
        // abort while idle leaves the last board alone
        abort_a = 1'b1;
        @(negedge clock);
        abort_a = 1'b0;
        total++;
        if (grid_a !== last_a || busy_a !== 1'b0) begin
            bad++; $display("FAIL abort_idle got grid=%b busy=%b want %b 0", grid_a, busy_a, last_a);
        end
        // abort during CLEAR
        start_a = 1'b1;
        safe_a  = 8'd4;
        @(negedge clock);
        start_a = 1'b0;
        abort_a = 1'b1;
        @(negedge clock);
        abort_a = 1'b0;
        total++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || grid_a !== 9'd0 || placed_a !== 8'd0) begin
            bad++; $display("FAIL abort_clear got busy=%b done=%b grid=%b placed=%0d want 0",
                            busy_a, done_a, grid_a, placed_a);
        end
        // abort three cycles after start, while still sampling
        safe = int'($urandom_range(0, 8));
        k = 0;
        predict(m_lfsr, safe, 2, exp, n);
        while (n < 3 && k < 300) begin
            @(negedge clock);
            predict(m_lfsr, safe, 2, exp, n);
            k++;
        end
        start_a = 1'b1;
        safe_a  = 8'(safe);
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        @(negedge clock);
        abort_a = 1'b1;
        @(negedge clock);
        abort_a = 1'b0;
        total++;
        if (busy_a !== 1'b0 || grid_a !== 9'd0 || placed_a !== 8'd0) begin
            bad++; $display("FAIL abort_sample got busy=%b grid=%b placed=%0d want 0 0 0",
                            busy_a, grid_a, placed_a);
        end
        dones = 0;
        for (int i = 0; i < n + 6; i++) begin
            if (done_a === 1'b1) dones++;
            @(negedge clock);
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL abort_nodone got=%0d want=0", dones);
        end
        // fresh placement after abort, with abort raised in DONE
        predict(m_lfsr, safe, 2, exp, n);
        start_a = 1'b1;
        safe_a  = 8'(safe);
        @(negedge clock);
        start_a = 1'b0;
        cyc = 1;
        while (done_a !== 1'b1 && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
        end
        total++;
        if (cyc != 2 + n || grid_a !== exp) begin
            bad++; $display("FAIL abort_restart got cyc=%0d grid=%b want %0d %b", cyc, grid_a, 2 + n, exp);
        end
        abort_a = 1'b1;
        @(negedge clock);
        abort_a = 1'b0;
        total++;
        if (grid_a !== exp || placed_a !== 8'd2 || busy_a !== 1'b0) begin
            bad++; $display("FAIL abort_done got grid=%b placed=%0d want %b 2", grid_a, placed_a, exp);
        end
        last_a = exp;
    endtask

    task automatic test_reset_mid();
        int         safe, n, cyc, gap, k;
        logic [8:0] exp;
        safe = int'($urandom_range(0, 8));
        k = 0;
        predict(m_lfsr, safe, 2, exp, n);
        while (n < 3 && k < 300) begin
            @(negedge clock);
            predict(m_lfsr, safe, 2, exp, n);
            k++;
        end
        start_a = 1'b1;
        safe_a  = 8'(safe);
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({grid_a, busy_a, done_a, placed_a} !== 19'd0) begin
            bad++; $display("FAIL reset_async got=%0h want=0", {grid_a, busy_a, done_a, placed_a});
        end
        @(negedge clock);
        gap  = int'($urandom_range(0, 30));
        safe = int'($urandom_range(0, 8));
        for (int r = 0; r < 2; r++) begin
            reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
            repeat (gap) @(negedge clock);
            predict(m_lfsr, safe, 2, exp, n);
            start_a = 1'b1;
            safe_a  = 8'(safe);
            @(negedge clock);
            start_a = 1'b0;
            cyc = 1;
            while (done_a !== 1'b1 && cyc < LIMIT) begin
                @(negedge clock);
                cyc++;
            end
            total++;
            if (cyc != 2 + n || grid_a !== exp) begin
                bad++; $display("FAIL reset_rerun run=%0d got cyc=%0d grid=%b want %0d %b",
                                r, cyc, grid_a, 2 + n, exp);
            end
            @(negedge clock);
        end
        last_a = exp;
    endtask

    task automatic test_start_held();
        int         safe, n, dones, dcyc;
        logic [8:0] exp, gridv;
        safe = int'($urandom_range(0, 8));
        predict(m_lfsr, safe, 2, exp, n);
        dones = 0;
        dcyc  = 0;
        gridv = 9'd0;
        start_a = 1'b1;
        safe_a  = 8'(safe);
        for (int cyc = 1; cyc <= n + 8; cyc++) begin
            @(negedge clock);
            safe_a = 8'($urandom);
            if (done_a === 1'b1) begin
                dones++;
                dcyc    = cyc;
                gridv   = grid_a;
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        total++;
        if (dones != 1 || dcyc != 2 + n) begin
            bad++; $display("FAIL held_done got count=%0d cyc=%0d want 1 %0d", dones, dcyc, 2 + n);
        end
        total++;
        if (gridv !== exp || (gridv & safe_mask(safe)) != 9'd0) begin
            bad++; $display("FAIL held_grid got=%b want=%b", gridv, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_full();
        test_abort();
        test_reset_mid();
        test_start_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
